// File: rtl/stg_xt_seq.sv
// stg_xt_seq: expand-translate stage between fetch latch and decode.
// RU/RS/IU/IS/SR words pass through as one micro-op. ISA-set macros
// (PUSH, POP, JSR/JSRi, BSR/BSRi, RET) are sequenced into 2-3 native
// micro-ops while ow_stall_up holds fetch.
// Optional feature macro: XT_TRAP_ILLEGAL_EN adds ow_illegal, a registered flag
// raised on the bubble emitted for an unknown opcode or instruction set.
//
// Word layout (DATA_W bits, requires ADDR_W <= DATA_W-8):
//   [DATA_W-1 -: 3] set, [DATA_W-4 -: 5] op, [DATA_W-9 -: 4] rd/reg,
//   [DATA_W-13 -: 4] rs, [15:0] imm; address forms carry [ADDR_W-1:0].
// STI and the immediate jump forms use the address layout, with SP implied
// as the STI base.
module stg_xt_seq #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int SP_IDX   = 15,
  parameter int TMP_IDX  = 14,
  parameter int MAX_UOPS = 4,
  localparam int UIDX_W  = (MAX_UOPS > 2) ? $clog2(MAX_UOPS) : 1
)(
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic              iw_flush,
  input  logic              iw_stall,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [UIDX_W-1:0] ow_uidx,
  output logic              ow_ulast,
  output logic              ow_stall_up
`ifdef XT_TRAP_ILLEGAL_EN
  , output logic            ow_illegal
`endif
);
  localparam int F_SET = DATA_W-1;
  localparam int F_OP  = DATA_W-4;
  localparam int F_RD  = DATA_W-9;
  localparam int F_RS  = DATA_W-13;

  // instruction sets
  localparam logic [2:0] SET_RU = 3'd1, SET_RS = 3'd2, SET_IU = 3'd3,
                         SET_IS = 3'd4, SET_SR = 3'd5, SET_ISA = 3'd6;
  // ISA-set macro opcodes
  localparam logic [4:0] OP_PUSH = 5'd0, OP_POP = 5'd1, OP_JSR = 5'd2, OP_JSRI = 5'd3,
                         OP_BSR = 5'd4, OP_BSRI = 5'd5, OP_RET = 5'd6;
  // native micro-op opcodes (IS / IU / SR sets)
  localparam logic [4:0] OP_ADDI = 5'd0, OP_LD = 5'd1, OP_ST = 5'd2, OP_STI = 5'd3;
  localparam logic [4:0] OP_JMP = 5'd0, OP_JMPI = 5'd1, OP_BRA = 5'd2, OP_BRAI = 5'd3;

  localparam logic [3:0]        SP   = 4'(SP_IDX);
  localparam logic [3:0]        TMP  = 4'(TMP_IDX);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [15:0]       IM_M1 = 16'hFFFF;
  localparam logic [15:0]       IM_P1 = 16'h0001;

  typedef enum logic {S_IDLE, S_SEQ} state_t;

  function automatic logic [DATA_W-1:0] f_word(input logic [2:0] set, input logic [4:0] op,
      input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm);
    logic [DATA_W-1:0] w;
    w = '0;
    w[15:0]     = imm;
    w[F_RS-:4]  = rs;
    w[F_RD-:4]  = rd;
    w[F_OP-:5]  = op;
    w[F_SET-:3] = set;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] f_addr(input logic [2:0] set, input logic [4:0] op,
      input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ADDR_W-1:0] = a;
    w[F_OP-:5]    = op;
    w[F_SET-:3]   = set;
    return w;
  endfunction

  // micro-op count of an instruction; 1 for everything that is not a known macro
  function automatic logic [2:0] f_n(input logic [2:0] set, input logic [4:0] op);
    if (set != SET_ISA) return 3'd1;
    case (op)
      OP_PUSH, OP_POP:                    return 3'd2;
      OP_JSR, OP_JSRI, OP_BSR, OP_BSRI,
      OP_RET:                             return 3'd3;
      default:                            return 3'd1;
    endcase
  endfunction

  // micro-op k of a macro
  function automatic logic [DATA_W-1:0] f_uop(input logic [4:0] op, input logic [3:0] rg,
      input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] pc, input logic [UIDX_W-1:0] k);
    logic [DATA_W-1:0] u;
    u = '0;
    case (op)
      OP_PUSH: u = (k == '0) ? f_word(SET_IS, OP_ADDI, SP, SP, IM_M1)
                             : f_word(SET_IS, OP_ST, rg, SP, '0);
      OP_POP:  u = (k == '0) ? f_word(SET_IS, OP_LD, rg, SP, '0)
                             : f_word(SET_IS, OP_ADDI, SP, SP, IM_P1);
      OP_JSR, OP_JSRI, OP_BSR, OP_BSRI: begin
        if (k == '0)                u = f_word(SET_IS, OP_ADDI, SP, SP, IM_M1);
        else if (k == UIDX_W'(1))   u = f_addr(SET_IU, OP_STI, pc + ONE); // wraps mod 2^ADDR_W
        else if (op == OP_JSR)      u = f_word(SET_SR, OP_JMP, '0, rg, '0);
        else if (op == OP_JSRI)     u = f_addr(SET_SR, OP_JMPI, tgt);
        else if (op == OP_BSR)      u = f_word(SET_SR, OP_BRA, '0, rg, '0);
        else                        u = f_addr(SET_SR, OP_BRAI, tgt);
      end
      OP_RET: begin
        if (k == '0)                u = f_word(SET_IS, OP_LD, TMP, SP, '0);
        else if (k == UIDX_W'(1))   u = f_word(SET_IS, OP_ADDI, SP, SP, IM_P1);
        else                        u = f_word(SET_SR, OP_JMP, '0, TMP, '0);
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  state_t            r_state, w_nxt_state;
  logic [UIDX_W-1:0] r_cnt, w_nxt_cnt;
  logic [DATA_W-1:0] r_mac;
  logic [ADDR_W-1:0] r_mpc;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [DATA_W-1:0] r_word, w_word;
  logic [UIDX_W-1:0] r_uidx, w_uidx;
  logic              r_ulast, w_ulast;
  logic              w_cap;
  logic [2:0]        w_set_in, w_n_in, w_n_mac;
  logic              w_pass_in;

  assign w_set_in  = iw_instr[F_SET-:3];
  assign w_n_in    = f_n(w_set_in, iw_instr[F_OP-:5]);
  assign w_n_mac   = f_n(r_mac[F_SET-:3], r_mac[F_OP-:5]);
  assign w_pass_in = (w_set_in == SET_RU) || (w_set_in == SET_RS) || (w_set_in == SET_IU) ||
                     (w_set_in == SET_IS) || (w_set_in == SET_SR);

  // next-state and next-output decode for the sequencer
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_pc        = iw_pc;
    w_word      = '0;
    w_uidx      = '0;
    w_ulast     = 1'b1;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_n_in > 3'd1) begin
          w_word      = f_uop(iw_instr[F_OP-:5], iw_instr[F_RD-:4], iw_instr[ADDR_W-1:0],
                              iw_pc, '0);
          w_ulast     = 1'b0;
          w_cap       = 1'b1;
          w_nxt_cnt   = UIDX_W'(1);
          w_nxt_state = S_SEQ;
        end else if (w_pass_in) begin
          w_word = iw_instr;
        end
      end
      S_SEQ: begin
        w_pc    = r_mpc;
        w_word  = f_uop(r_mac[F_OP-:5], r_mac[F_RD-:4], r_mac[ADDR_W-1:0], r_mpc, r_cnt);
        w_uidx  = r_cnt;
        w_ulast = (3'(r_cnt) == (w_n_mac - 3'd1));
        if (w_ulast) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt   = r_cnt + UIDX_W'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // state, capture and output latches: reset > flush > stall > advance
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mac   <= '0;
      r_mpc   <= '0;
      r_pc    <= '0;
      r_word  <= '0;
      r_uidx  <= '0;
      r_ulast <= 1'b0;
    end else if (iw_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_word  <= '0;
      r_uidx  <= '0;
      r_ulast <= 1'b0;
    end else if (!iw_stall) begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_pc    <= w_pc;
      r_word  <= w_word;
      r_uidx  <= w_uidx;
      r_ulast <= w_ulast;
      if (w_cap) begin
        r_mac <= iw_instr;
        r_mpc <= iw_pc;
      end
    end
  end

`ifdef XT_TRAP_ILLEGAL_EN
  logic r_ill, w_ill;
  // a non-zero word that is neither pass-through nor a known macro is illegal
  assign w_ill = (r_state == S_IDLE) && (iw_instr != '0) && !w_pass_in && (w_n_in == 3'd1);

  // trap flag follows the output latch: cleared by reset/flush, held by stall
  always_ff @(posedge iw_clk) begin
    if (iw_rst || iw_flush) r_ill <= 1'b0;
    else if (!iw_stall)     r_ill <= w_ill;
  end
  assign ow_illegal = r_ill;
`endif

  assign ow_pc       = r_pc;
  assign ow_instr    = r_word;
  assign ow_uidx     = r_uidx;
  assign ow_ulast    = r_ulast;
  assign ow_stall_up = iw_stall | (r_state == S_SEQ);
endmodule

// File: tb/tb_stg_xt_seq.sv
// tb_stg_xt_seq: directed scoreboard bench for stg_xt_seq (ADDR_W=24, DATA_W=32).
// Expected micro-ops are written out as literal words in the stage's encoding and
// queued as stimulus is planned; each clock pops one entry and compares.
module tb_stg_xt_seq;
  logic        clk = 1'b0;
  logic        rst, flush, stall;
  logic [23:0] pc;
  logic [31:0] instr;
  logic [23:0] o_pc;
  logic [31:0] o_instr;
  logic [1:0]  o_uidx;
  logic        o_ulast, o_su;
`ifdef XT_TRAP_ILLEGAL_EN
  logic        o_ill;
`endif

  always #5 clk = ~clk;

  stg_xt_seq dut (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr),
    .iw_flush(flush), .iw_stall(stall),
    .ow_pc(o_pc), .ow_instr(o_instr), .ow_uidx(o_uidx), .ow_ulast(o_ulast),
    .ow_stall_up(o_su)
`ifdef XT_TRAP_ILLEGAL_EN
    , .ow_illegal(o_ill)
`endif
  );

  typedef struct {
    logic [23:0] pc;
    logic [31:0] ins;
    logic [1:0]  uidx;
    logic        ulast;
    logic        su;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [23:0] p, input logic [31:0] w, input logic [1:0] ui,
                    input logic ul, input logic su, input logic il);
    exp_t e;
    e.pc = p; e.ins = w; e.uidx = ui; e.ulast = ul; e.su = su; e.ill = il;
    q.push_back(e);
  endtask

  // drive one cycle of inputs, then compare the latched result against the next queued entry
  task automatic step(input logic [23:0] p, input logic [31:0] w, input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    pc = p; instr = w; stall = st; flush = fl;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = q.pop_front();
      chk("pc",       {8'h0, o_pc},      {8'h0, e.pc});
      chk("instr",    o_instr,           e.ins);
      chk("uidx",     {30'h0, o_uidx},   {30'h0, e.uidx});
      chk("ulast",    {31'h0, o_ulast},  {31'h0, e.ulast});
      chk("stall_up", {31'h0, o_su},     {31'h0, e.su});
`ifdef XT_TRAP_ILLEGAL_EN
      chk("illegal",  {31'h0, o_ill},    {31'h0, e.ill});
`endif
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; pc = '0; instr = '0;

    // reset with random pc/instr/flush for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pc = 24'($urandom); instr = $urandom; flush = 1'($urandom);
      @(posedge clk);
    end
    #1;
    chk("rst_pc",       {8'h0, o_pc},     32'h0);
    chk("rst_instr",    o_instr,          32'h0);
    chk("rst_uidx",     {30'h0, o_uidx},  32'h0);
    chk("rst_ulast",    {31'h0, o_ulast}, 32'h0);
    chk("rst_stall_up", {31'h0, o_su},    32'h0);
`ifdef XT_TRAP_ILLEGAL_EN
    chk("rst_illegal",  {31'h0, o_ill},   32'h0);
`endif
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;

    // RU ADD pass-through
    ex(24'h10, 32'h2012_0005, 0, 1, 0, 0);
    step(24'h10, 32'h2012_0005, 0, 0);

    // other pass-through sets: RS, IU, IS, SR
    ex(24'h11, 32'h4123_4567, 0, 1, 0, 0);
    ex(24'h12, 32'h6ABC_0001, 0, 1, 0, 0);
    ex(24'h13, 32'h8001_0002, 0, 1, 0, 0);
    ex(24'h14, 32'hA300_0000, 0, 1, 0, 0);
    step(24'h11, 32'h4123_4567, 0, 0);
    step(24'h12, 32'h6ABC_0001, 0, 0);
    step(24'h13, 32'h8001_0002, 0, 0);
    step(24'h14, 32'hA300_0000, 0, 0);

    // PUSH R3: ADDi SP,SP,-1 ; ST R3,[SP]; 0x21 held by fetch then emitted
    ex(24'h20, 32'h80FF_FFFF, 0, 0, 1, 0);
    ex(24'h20, 32'h823F_0000, 1, 1, 0, 0);
    ex(24'h21, 32'h2034_0000, 0, 1, 0, 0);
    step(24'h20, 32'hC030_0000, 0, 0);
    step(24'h21, 32'h2034_0000, 0, 0);
    step(24'h21, 32'h2034_0000, 0, 0);

    // POP R5: LD R5,[SP] ; ADDi SP,SP,+1
    ex(24'h30, 32'h815F_0000, 0, 0, 1, 0);
    ex(24'h30, 32'h80FF_0001, 1, 1, 0, 0);
    step(24'h30, 32'hC150_0000, 0, 0);
    step(24'h31, 32'h0000_0000, 0, 0);

    // JSRi 0x123456 at pc 0xFFFFFF, stall held 3 cycles on uop1; return address wraps to 0
    ex(24'hFFFFFF, 32'h80FF_FFFF, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) ex(24'hFFFFFF, 32'h6300_0000, 1, 0, 1, 0);
    ex(24'hFFFFFF, 32'hA112_3456, 2, 1, 0, 0);
    step(24'hFFFFFF, 32'hC312_3456, 0, 0);
    step(24'h000000, 32'h0000_0000, 0, 0);
    for (int i = 0; i < 3; i++) step(24'h000000, 32'h0000_0000, 1, 0);
    step(24'h000000, 32'h0000_0000, 0, 0);

    // BSR R7 at 0x40: ADDi ; STI 0x41 ; BRA R7
    ex(24'h40, 32'h80FF_FFFF, 0, 0, 1, 0);
    ex(24'h40, 32'h6300_0041, 1, 0, 1, 0);
    ex(24'h40, 32'hA207_0000, 2, 1, 0, 0);
    step(24'h40, 32'hC470_0000, 0, 0);
    step(24'h41, 32'h0000_0000, 0, 0);
    step(24'h41, 32'h0000_0000, 0, 0);

    // RET flushed while uop1 is on the output, then an RU word proceeds normally
    ex(24'h50, 32'h81EF_0000, 0, 0, 1, 0);
    ex(24'h50, 32'h80FF_0001, 1, 0, 1, 0);
    ex(24'h00, 32'h0000_0000, 0, 0, 0, 0);
    ex(24'h51, 32'h2012_0005, 0, 1, 0, 0);
    step(24'h50, 32'hC600_0000, 0, 0);
    step(24'h51, 32'h2012_0005, 0, 0);
    step(24'h51, 32'h2012_0005, 0, 1);
    step(24'h51, 32'h2012_0005, 0, 0);

    // undefined ISA opcode, unknown set, and a true bubble
    ex(24'h60, 32'h0000_0000, 0, 1, 0, 1);
    ex(24'h61, 32'h0000_0000, 0, 1, 0, 1);
    ex(24'h62, 32'h0000_0000, 0, 1, 0, 0);
    step(24'h60, 32'hC700_0000, 0, 0);
    step(24'h61, 32'hE000_0001, 0, 0);
    step(24'h62, 32'h0000_0000, 0, 0);

    // stall in idle freezes outputs; flush beats a concurrent stall
    ex(24'h62, 32'h0000_0000, 0, 1, 1, 0);
    ex(24'h70, 32'h2055_0000, 0, 1, 0, 0);
    ex(24'h00, 32'h0000_0000, 0, 0, 1, 0);
    ex(24'h71, 32'h2066_0000, 0, 1, 0, 0);
    step(24'h70, 32'h2055_0000, 1, 0);
    step(24'h70, 32'h2055_0000, 0, 0);
    step(24'h71, 32'h2066_0000, 1, 1);
    step(24'h71, 32'h2066_0000, 0, 0);

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
